sqrt_rr_scheduler: RTL and testbench

//  Shares one squareroot_AHSQR_k14 unit among NREQ gradient-magnitude requesters in the Sobel edge path.

---
 rtl/sqrt_rr_scheduler.sv | 143 ++++++++++++++
 tb/tb_sqrt_rr_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_rr_scheduler.sv
// sqrt_rr_scheduler
//   Shares one approximate square-root unit among NREQ gradient-magnitude
//   requesters in the Sobel edge path. The requesters are served round-robin.
//   The pipeline has two stages: S1 holds the operand, and S2 holds the result.
//   The sqrt logic sits between S1 and S2. Each result is tagged with the id
//   of the requester that issued it. The scheduler sustains one result per
//   cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  [NREQ]     requester i presents a radicand
//   req_data   [NREQ*DW]  radicand of requester i in [i*DW +: DW]
//   req_ready  [NREQ]     one-hot (or zero) accept strobe
//   res_valid             S2 holds a result
//   res_data   [QW]       approximate square root
//   res_id     [IDW]      requester the result belongs to
//   res_ready             downstream accepts the result
//   busy                  S1 or S2 holds data
module sqrt_rr_scheduler #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int DW   = 16,
  parameter int QW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  output logic [QW-1:0]        res_data,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready,
  output logic                 busy
);

  // Shared sqrt unit: isqrt(v >> 2) by the shift-subtract method, 7-bit root.
  // The full radicand is passed in so that the two discarded LSBs stay visible
  // at this interface.
  function automatic logic [6:0] isqrt_ahsqr(input logic [15:0] v);
    logic [13:0] op;
    logic [13:0] res;
    logic [13:0] one;
    op  = v[15:2];
    res = '0;
    one = 14'h1000;
    for (int i = 0; i < 7; i++) begin
      if (op >= res + one) begin
        op  = op - (res + one);
        res = (res >> 1) + one;
      end else begin
        res = res >> 1;
      end
      one = one >> 2;
    end
    return res[6:0];
  endfunction

  logic              s1_v, s2_v;
  logic [DW-1:0]     s1_rad;
  logic [IDW-1:0]    s1_id, s2_id;
  logic [QW-1:0]     s2_q;
  logic [IDW-1:0]    rr_ptr;

  logic              s2_free, s1_free, hs;
  logic              gnt_any;
  logic [IDW-1:0]    gnt_id;
  logic [NREQ-1:0]   gnt_oh;
  logic [DW-1:0]     sel_rad;
  logic [QW-2:0]     root;
  logic [QW-1:0]     sqrt_q;

  assign s2_free = !s2_v || res_ready;
  assign s1_free = !s1_v || s2_free;

  // Round-robin pick. The first pass covers indices at or above rr_ptr. The
  // second pass wraps around to index 0 and is used only when the first pass
  // finds nothing.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
  end

  always_comb begin
    gnt_oh  = '0;
    sel_rad = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i] = gnt_any && (gnt_id == IDW'(i));
      if (gnt_oh[i]) sel_rad = req_data[i*DW +: DW];
    end
  end

  assign hs        = gnt_any && s1_free && !rst;
  assign req_ready = hs ? gnt_oh : '0;

  // Bit 0 from the unit is unreliable. It is replaced by a flag that marks a
  // zero root, so inputs 0..3 report 1 rather than 0.
  assign root   = isqrt_ahsqr(s1_rad);
  assign sqrt_q = {root, (root == '0)};

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      s1_v   <= 1'b0;
      s1_rad <= '0;
      s1_id  <= '0;
      s2_v   <= 1'b0;
      s2_q   <= '0;
      s2_id  <= '0;
    end else begin
      if (hs) rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
      if (s1_free) begin
        s1_v   <= hs;
        s1_rad <= sel_rad;
        s1_id  <= gnt_id;
      end
      if (s2_free) begin
        s2_v  <= s1_v;
        s2_q  <= sqrt_q;
        s2_id <= s1_id;
      end
    end
  end

  assign res_valid = s2_v;
  assign res_data  = s2_q;
  assign res_id    = s2_id;
  assign busy      = s1_v || s2_v;

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
module tb_sqrt_rr_scheduler;
  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int DW   = 16;
  localparam int QW   = 8;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic [QW-1:0]      res_data;
  logic [IDW-1:0]     res_id;
  logic               res_ready;
  logic               busy;

  sqrt_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .QW(QW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit              m_s1v, m_s2v, stall_prev;
  int              m_ptr;
  logic [QW-1:0]   prev_data;
  logic [IDW-1:0]  prev_id;
  logic [NREQ-1:0] last_hs;
  int              q_data[$];
  int              q_id[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference root by linear search: {isqrt(r>>2), root==0}.
  function automatic int ref_root(input int r);
    int v, q;
    v = r >> 2;
    q = 0;
    while ((q + 1) * (q + 1) <= v) q++;
    return (q << 1) | ((q == 0) ? 1 : 0);
  endfunction

  // Entered at a negative edge with the inputs already driven. This task
  // checks the outputs against the model, updates the scoreboard, and returns
  // at the next negative edge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int g, j;
    bit s1f, s2f;
    #1;
    s2f = !m_s2v || res_ready;
    s1f = !m_s1v || s2f;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (g < 0 && req_valid[j]) g = j;
    end
    exp_rdy = '0;
    if (g >= 0 && s1f && !rst) exp_rdy[g] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_val("res_valid", 32'(res_valid), 32'(m_s2v));
    check_val("busy", 32'(busy), 32'(m_s1v | m_s2v));
    if (stall_prev && !rst) begin
      check_val("hold_data", 32'(res_data), 32'(prev_data));
      check_val("hold_id", 32'(res_id), 32'(prev_id));
    end
    last_hs = req_valid & req_ready;
    if (rst) begin
      q_data.delete();
      q_id.delete();
      m_s1v = 0; m_s2v = 0; m_ptr = 0; stall_prev = 0;
    end else begin
      if (res_valid && res_ready) begin
        if (q_data.size() == 0) check_val("spurious_result", 32'(res_valid), 32'd0);
        else begin
          check_val("res_data", 32'(res_data), 32'(q_data.pop_front()));
          check_val("res_id", 32'(res_id), 32'(q_id.pop_front()));
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (last_hs[i]) begin
          q_data.push_back(ref_root(int'(req_data[i*DW +: DW])));
          q_id.push_back(i);
        end
      stall_prev = res_valid && !res_ready;
      prev_data  = res_data;
      prev_id    = res_id;
      if (s2f) m_s2v = m_s1v;
      if (s1f) m_s1v = (exp_rdy != '0);
      if (exp_rdy != '0) m_ptr = (g == NREQ-1) ? 0 : g + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic single(input int idx, input logic [15:0] r, input int exp);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_data[idx*DW +: DW] = r;
    res_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    #1;
    check_val("lat_valid", 32'(res_valid), 32'd1);
    check_val("edge_data", 32'(res_data), 32'(exp));
    check_val("edge_id", 32'(res_id), 32'(idx));
    step();
  endtask

  task automatic refresh_accepted();
    for (int i = 0; i < NREQ; i++)
      if (last_hs[i]) req_data[i*DW +: DW] = 16'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] gnt, prev_gnt;
    clk = 0; rst = 1; req_valid = '0; req_data = '0; res_ready = 1'b1;
    m_s1v = 0; m_s2v = 0; m_ptr = 0; stall_prev = 0; last_hs = '0;
    prev_data = '0; prev_id = '0; prev_gnt = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_res_data", 32'(res_data), 32'd0);
    check_val("rst_res_id", 32'(res_id), 32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst = 0;

    // Single requests and edge values.
    single(0, 16'd400, 20);
    single(1, 16'd3, 1);
    single(0, 16'd1024, 32);
    single(1, 16'd65535, 254);
    single(0, 16'd0, 1);

    // Both requesters valid every cycle: grants alternate, one result per cycle.
    req_data = {16'd900, 16'd100};
    req_valid = 2'b11;
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      gnt = req_ready;
      if (c > 0) check_val("alt_grant", 32'(gnt), 32'({prev_gnt[0], prev_gnt[1]}));
      if (c >= 2) check_val("stream_valid", 32'(res_valid), 32'd1);
      prev_gnt = gnt;
      step();
      refresh_accepted();
    end
    req_valid = '0;
    repeat (3) step();

    // Backpressure: fill the pipe, then stall for more than five cycles.
    req_valid = 2'b11;
    res_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c >= 2) check_val("bp_ready", 32'(req_ready), 32'd0);
      step();
      refresh_accepted();
    end
    res_ready = 1'b1;
    req_valid = '0;
    repeat (4) step();
    check_val("bp_drain", 32'(q_data.size()), 32'd0);

    // Reset with both stages full and rr_ptr at 1.
    res_ready = 1'b0;
    req_valid = 2'b10;
    step();
    req_valid = 2'b01;
    step();
    #1;
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req_valid = 2'b11;
    step();
    rst = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    check_val("post_rst_valid", 32'(res_valid), 32'd0);
    check_val("post_rst_busy", 32'(busy), 32'd0);
    step();
    req_valid = 2'b11;
    #1;
    check_val("post_rst_ptr", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    repeat (3) step();

    // Random valid/ready against the scoreboard.
    last_hs = '0;
    req_valid = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_hs[i]) begin
          if ($urandom_range(0, 9) < 6) begin
            req_valid[i] = 1'b1;
            if ($urandom_range(0, 3) == 0) req_data[i*DW +: DW] = 16'($urandom_range(0, 20));
            else req_data[i*DW +: DW] = 16'($urandom);
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    for (int c = 0; c < 20 && q_data.size() != 0; c++) step();
    check_val("rand_drain", 32'(q_data.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
